pe_mac_sequencer: RTL and testbench
===================================

// Module: pe_mac_sequencer
// PURPOSE
//  Sequences one SV_PE through 1-D dot-product jobs.
//  - Joins the ifmap and filter operand streams and issues one operand pair per cycle to the PE.
//  - Drives the PE accumulator controls: mult select and accumulator clear.
//  - Waits out the PE pipeline, then captures the finished psum.
//  - Returns the psum on a valid/ready stream.
//  - Sits between the buffer/scheduler layer and a single PE.
// PARAMETERS
//  DATA_WIDTH  16  operand width (ifmap, filter)
//  PSUM_WIDTH  32  psum width; must be >= 2*DATA_WIDTH
//  CNT_WIDTH   8   width of the tap and output counters
//  MULT_LAT    2   multiplier latency in cycles (issue -> product)
// PORTS
//  clk           in   1           clock; all logic on rising edge
//  rst           in   1           synchronous reset, active-high
//  start         in   1           pulse; latches cfg_*, begins job (ignored unless IDLE)
//  cfg_taps      in   CNT_WIDTH   taps per output (K); 0 treated as 1
//  cfg_outputs   in   CNT_WIDTH   outputs per job (N); 0 -> immediate done
//  ifm_data      in   DATA_WIDTH  ifmap operand
//  ifm_valid     in   1           ifmap operand valid
//  ifm_ready     out  1           ifmap operand accepted
//  flt_data      in   DATA_WIDTH  filter operand
//  flt_valid     in   1           filter operand valid
//  flt_ready     out  1           filter operand accepted
//  pe_ifmap      out  DATA_WIDTH  operand a to PE multiplier (registered)
//  pe_fltr       out  DATA_WIDTH  operand b to PE multiplier (registered)
//  pe_mult_sel   out  1           1: accumulator adds product; 0: adds nothing/bypass
//  pe_acc_clr    out  1           1: accumulator restarts from current product
//  pe_psum       in   PSUM_WIDTH  PE accumulator value
//  psum_data     out  PSUM_WIDTH  captured result
//  psum_valid    out  1           result valid; held until psum_ready
//  psum_ready    in   1           downstream accepts result
//  busy          out  1           high in any state except IDLE
//  done          out  1           1-cycle pulse after the last result is accepted
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; all counters and the tag pipe cleared.
//    Reset mid-job aborts the job: no done pulse, partial psum discarded.
//  FSM states:
//    IDLE  -> MAC    on start, when N != 0
//    IDLE  -> DONE   on start, when N == 0
//    MAC   -> DRAIN  when the K-th pair issues
//    DRAIN -> OUT    after MULT_LAT+1 cycles; psum_data <= pe_psum on exit
//    OUT   -> MAC    on psum_valid&&psum_ready, when more outputs remain
//    OUT   -> DONE   on psum_valid&&psum_ready, when it was output N
//    DONE  -> IDLE   unconditionally; done=1 for exactly this cycle
//  Operand join (MAC only):
//    - issue = ifm_valid && flt_valid.
//    - ifm_ready = flt_ready = issue. Never accept one operand without the other.
//    - On issue: pe_ifmap/pe_fltr <= data, and the tap counter increments.
//    - No issue -> bubble; operand registers hold their values.
//  Tag pipe: MULT_LAT-deep shift register carrying {valid, first}, where first = (tap==0).
//    - pe_mult_sel = tag valid at the pipe output.
//    - pe_acc_clr = valid && first at the pipe output.
//    - Bubbles therefore add nothing to the psum.
//  Latency: last pair issued at cycle t -> psum_valid at t+MULT_LAT+2 when there are no stalls.
//  psum_data and psum_valid are stable while psum_valid && !psum_ready.
//    No new operands are accepted in OUT.
//  start during busy: ignored; cfg is not relatched.
//  Counter wrap: the tap counter resets to 0 per output and the output counter to 0 per job.
//    Neither counter ever wraps mid-job.
//  Arithmetic: PE accumulates signed values; the sequencer never modifies psum (except bias, below).
// CONFIGURATION
//  PE_SEQ_BIAS_EN defined:
//    - Adds port cfg_bias (in, PSUM_WIDTH, signed), latched on start.
//    - Capture becomes psum_data <= pe_psum + cfg_bias, signed, wrap on overflow.
//  PE_SEQ_BIAS_EN undefined: no cfg_bias port; psum_data <= pe_psum.
// TESTING
//  T1 basic:
//    - Stimulus: K=3, N=2; ifm 1,2,3,4,5,6; flt 1,1,1,1,1,1; always valid/ready.
//    - Response: psum 6 then 15; done 1 cycle after the 2nd accept.
//  T2 latency:
//    - Stimulus: K=1, N=1; ifm=7, flt=-3.
//    - Response: psum=-21; psum_valid exactly MULT_LAT+2 cycles after the issue cycle.
//  T3 stalls:
//    - Stimulus: as T1, with flt_valid low every other cycle.
//    - Response: same results 6/15; ifm_ready never high while flt_valid=0.
//  T4 backpressure:
//    - Stimulus: as T1, psum_ready low 5 cycles.
//    - Response: psum_data holds 6 and no operand is accepted until the handshake.
//  T5 edges:
//    - Stimulus A: N=0. Response: busy 1 cycle, then done.
//    - Stimulus B: K=0. Response: behaves as K=1.
//    - Stimulus C: start while busy. Response: ignored.
//  T6 reset/bias:
//    - Stimulus A: rst mid-MAC. Response: all outputs 0, IDLE, no done.
//    - Stimulus B: with PE_SEQ_BIAS_EN, T1 with bias=-4. Response: psum 2 then 11.

Source files
------------

// File: rtl/pe_mac_sequencer.sv
// Sequences one PE through 1-D dot-product jobs: joins operand streams, drives accumulator controls, returns psums.
// Optional macro PE_SEQ_BIAS_EN adds a latched signed cfg_bias added to every captured psum.
module pe_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int MULT_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_taps,
  input  logic [CNT_WIDTH-1:0]  cfg_outputs,
`ifdef PE_SEQ_BIAS_EN
  input  logic [PSUM_WIDTH-1:0] cfg_bias,
`endif
  input  logic [DATA_WIDTH-1:0] ifm_data,
  input  logic                  ifm_valid,
  output logic                  ifm_ready,
  input  logic [DATA_WIDTH-1:0] flt_data,
  input  logic                  flt_valid,
  output logic                  flt_ready,
  output logic [DATA_WIDTH-1:0] pe_ifmap,
  output logic [DATA_WIDTH-1:0] pe_fltr,
  output logic                  pe_mult_sel,
  output logic                  pe_acc_clr,
  input  logic [PSUM_WIDTH-1:0] pe_psum,
  output logic [PSUM_WIDTH-1:0] psum_data,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

  localparam int DRAIN_W = $clog2(MULT_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MULT_LAT);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  taps_q, outs_q, tap_cnt, out_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [MULT_LAT-1:0]   tag_valid, tag_first;
  logic [PSUM_WIDTH-1:0] bias_q;
  logic                  issue, accept, last_tap, last_out, drain_done;

  assign last_tap   = (tap_cnt == taps_q - CNT_WIDTH'(1));
  assign last_out   = (out_cnt == outs_q - CNT_WIDTH'(1));
  assign drain_done = (drain_cnt == DRAIN_LAST);
  assign ifm_ready  = issue;
  assign flt_ready  = issue;
  // The tag pipe output lines up with the product leaving the PE multiplier.
  assign pe_mult_sel = tag_valid[MULT_LAT-1];
  assign pe_acc_clr  = tag_valid[MULT_LAT-1] & tag_first[MULT_LAT-1];

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    accept     = 1'b0;
    psum_valid = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (cfg_outputs == '0) ? S_DONE : S_MAC;
      end
      S_MAC: begin
        issue = ifm_valid & flt_valid;
        if (issue && last_tap) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) state_nxt = S_OUT;
      end
      S_OUT: begin
        psum_valid = 1'b1;
        accept     = psum_ready;
        if (accept) state_nxt = last_out ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q    <= '0;
      outs_q    <= '0;
      tap_cnt   <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      tag_valid <= '0;
      tag_first <= '0;
      bias_q    <= '0;
      pe_ifmap  <= '0;
      pe_fltr   <= '0;
      psum_data <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        taps_q  <= (cfg_taps == '0) ? CNT_WIDTH'(1) : cfg_taps;
        outs_q  <= cfg_outputs;
        tap_cnt <= '0;
        out_cnt <= '0;
`ifdef PE_SEQ_BIAS_EN
        bias_q  <= cfg_bias;
`else
        bias_q  <= '0;
`endif
      end
      if (issue) begin
        pe_ifmap <= ifm_data;
        pe_fltr  <= flt_data;
        tap_cnt  <= last_tap ? '0 : tap_cnt + CNT_WIDTH'(1);
      end
      tag_valid[0] <= issue;
      tag_first[0] <= issue & (tap_cnt == '0);
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_first[i] <= tag_first[i-1];
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                  drain_cnt <= '0;
      // Capture on the last drain cycle, once the final product has been accumulated.
      if (state == S_DRAIN && drain_done) psum_data <= pe_psum + bias_q;
      if (accept) out_cnt <= last_out ? '0 : out_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Testbench for pe_mac_sequencer: PE model, table-driven jobs, randomized jobs, and corner sequences.
// Build with PE_SEQ_BIAS_EN defined to exercise the bias path.
module tb_pe_mac_sequencer;
  localparam int DW = 16, PW = 32, CW = 8, ML = 2;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [CW-1:0] cfg_taps, cfg_outputs;
  logic [DW-1:0] ifm_data, flt_data, pe_ifmap, pe_fltr;
  logic          ifm_valid, ifm_ready, flt_valid, flt_ready;
  logic          pe_mult_sel, pe_acc_clr, psum_valid, psum_ready, busy, done;
  logic [PW-1:0] pe_psum, psum_data;
`ifdef PE_SEQ_BIAS_EN
  logic [PW-1:0] cfg_bias;
`endif

  int     n_vec = 0, n_bad = 0;
  longint bias_val = 0;

  logic signed [DW-1:0] ifm_src[$], flt_src[$];
  logic signed [PW-1:0] exp_q[$], got_q[$];

  typedef struct {
    int     k, n, ifm0, fltv, stall, bp;
    bit     poke;
    longint exp_first, exp_last;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  pe_mac_sequencer #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .CNT_WIDTH(CW), .MULT_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_taps(cfg_taps), .cfg_outputs(cfg_outputs),
`ifdef PE_SEQ_BIAS_EN
    .cfg_bias(cfg_bias),
`endif
    .ifm_data(ifm_data), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
    .flt_data(flt_data), .flt_valid(flt_valid), .flt_ready(flt_ready),
    .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_mult_sel(pe_mult_sel), .pe_acc_clr(pe_acc_clr),
    .pe_psum(pe_psum), .psum_data(psum_data), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .busy(busy), .done(done)
  );

  // PE model: multiplier with ML cycles from operand issue to product, then accumulator.
  logic signed [PW-1:0] prod_pipe [ML-1];
  logic signed [PW-1:0] acc;
  assign pe_psum = acc;
  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      for (int i = 0; i < ML-1; i++) prod_pipe[i] <= '0;
    end else begin
      prod_pipe[0] <= PW'($signed(pe_ifmap)) * PW'($signed(pe_fltr));
      for (int i = 1; i < ML-1; i++) prod_pipe[i] <= prod_pipe[i-1];
      if (pe_mult_sel) acc <= pe_acc_clr ? prod_pipe[ML-2] : acc + prod_pipe[ML-2];
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: each output is the signed dot product of its K operand pairs plus bias, wrapped to PW.
  function automatic void build_job(input int k, input int n, input bit rnd, input int ifm0, input int fltv);
    int ke;
    longint sum;
    logic signed [DW-1:0] a, b;
    ke = (k == 0) ? 1 : k;
    ifm_src.delete(); flt_src.delete(); exp_q.delete();
    for (int o = 0; o < n; o++) begin
      sum = bias_val;
      for (int t = 0; t < ke; t++) begin
        a = rnd ? DW'($urandom) : DW'(ifm0 + o*ke + t);
        b = rnd ? DW'($urandom) : DW'(fltv);
        ifm_src.push_back(a);
        flt_src.push_back(b);
        sum += longint'(a) * longint'(b);
      end
      exp_q.push_back(PW'(sum));
    end
  endfunction

  task automatic applyStimulus(input int k, input int n, input int stall, input int bp, input bit poke);
    int  last_issue, last_accept, bp_left, accepts;
    bit  done_seen, pv_prev, held_v, s_ir, s_fr, s_pv, s_pr, s_done;
    logic [PW-1:0] s_pd, held;
    got_q.delete();
    start = 1'b1; cfg_taps = CW'(k); cfg_outputs = CW'(n);
`ifdef PE_SEQ_BIAS_EN
    cfg_bias = PW'(bias_val);
`endif
    @(posedge clk); #1;
    start = 1'b0; cfg_taps = CW'($urandom); cfg_outputs = CW'($urandom);
`ifdef PE_SEQ_BIAS_EN
    cfg_bias = PW'($urandom);
`endif
    last_issue = -100; last_accept = -100; bp_left = bp; accepts = 0;
    done_seen = 0; pv_prev = 0; held_v = 0; held = '0;
    for (int cyc = 0; cyc < BUDGET && !done_seen; cyc++) begin
      case (stall)
        0:       begin ifm_valid = 1'b1; flt_valid = 1'b1; end
        1:       begin ifm_valid = 1'b1; flt_valid = cyc[0]; end
        default: begin ifm_valid = 1'($urandom_range(0, 1)); flt_valid = 1'($urandom_range(0, 1)); end
      endcase
      if (ifm_src.size() == 0) begin
        ifm_valid = 1'b0; flt_valid = 1'b0; ifm_data = '0; flt_data = '0;
      end else begin
        ifm_data = ifm_src[0]; flt_data = flt_src[0];
      end
      psum_ready = (stall == 2) ? 1'($urandom_range(0, 1)) : (bp_left == 0);
      start = poke && (cyc == 2);
      #1;
      s_ir = ifm_ready; s_fr = flt_ready; s_pv = psum_valid; s_pr = psum_ready;
      s_pd = psum_data; s_done = done;
      checkOutput("join", longint'((s_ir == s_fr) && (!s_ir || (ifm_valid && flt_valid))), 1);
      if (s_pv) checkOutput("no_issue_in_out", longint'(s_ir), 0);
      if (s_pv && held_v) checkOutput("psum_hold", longint'($signed(s_pd)), longint'($signed(held)));
      if (s_pv && !pv_prev && stall == 0) checkOutput("latency", longint'(cyc - last_issue), ML + 2);
      if (s_done) begin
        checkOutput("done_after_accept", longint'(cyc - last_accept), 1);
        checkOutput("accept_count", longint'(accepts), longint'(n));
        done_seen = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (s_ir) begin
        void'(ifm_src.pop_front()); void'(flt_src.pop_front());
        last_issue = cyc;
      end
      if (s_pv && s_pr) begin
        got_q.push_back(s_pd); accepts++; last_accept = cyc; held_v = 0;
      end else if (s_pv) begin
        held_v = 1; held = s_pd;
        if (bp_left > 0) bp_left--;
      end
      pv_prev = s_pv;
    end
    ifm_valid = 1'b0; flt_valid = 1'b0; psum_ready = 1'b0;
    if (!done_seen) checkOutput("done_timeout", 0, 1);
    checkOutput("done_one_cycle", longint'(done), 0);
    checkOutput("idle_after_done", longint'(busy), 0);
    checkOutput("ops_consumed", longint'(ifm_src.size()), 0);
  endtask

  task automatic run_vector(input vec_t v, input bit use_tbl);
    build_job(v.k, v.n, !use_tbl, v.ifm0, v.fltv);
    applyStimulus(v.k, v.n, v.stall, v.bp, v.poke);
    checkOutput("psum_count", longint'(got_q.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) checkOutput("psum", longint'(got_q[i]), longint'(exp_q[i]));
    if (use_tbl && got_q.size() > 0) begin
      checkOutput("tbl_first", longint'(got_q[0]), v.exp_first + bias_val);
      checkOutput("tbl_last", longint'(got_q[got_q.size()-1]), v.exp_last + bias_val);
    end
  endtask

  initial begin
    vec_t rv;
    int   dones;
    tbl[0] = '{k:3, n:2, ifm0:1,  fltv:1,  stall:0, bp:0, poke:0, exp_first:6,   exp_last:15};
    tbl[1] = '{k:3, n:2, ifm0:1,  fltv:1,  stall:1, bp:0, poke:0, exp_first:6,   exp_last:15};
    tbl[2] = '{k:3, n:2, ifm0:1,  fltv:1,  stall:0, bp:5, poke:0, exp_first:6,   exp_last:15};
    tbl[3] = '{k:0, n:2, ifm0:1,  fltv:2,  stall:0, bp:0, poke:0, exp_first:2,   exp_last:4};
    tbl[4] = '{k:1, n:1, ifm0:7,  fltv:-3, stall:0, bp:0, poke:0, exp_first:-21, exp_last:-21};
    tbl[5] = '{k:4, n:3, ifm0:-2, fltv:3,  stall:0, bp:0, poke:1, exp_first:-6,  exp_last:90};

    rst = 1'b1; start = 1'b0; cfg_taps = '0; cfg_outputs = '0;
    ifm_data = '0; flt_data = '0; ifm_valid = 1'b0; flt_valid = 1'b0; psum_ready = 1'b0;
`ifdef PE_SEQ_BIAS_EN
    cfg_bias = '0;
    bias_val = -4;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_psum_valid", longint'(psum_valid), 0);
    checkOutput("rst_psum_data", longint'(psum_data), 0);
    checkOutput("rst_mult_sel", longint'(pe_mult_sel), 0);
    checkOutput("rst_pe_ifmap", longint'(pe_ifmap), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N == 0: a single busy cycle that is also the done cycle.
    start = 1'b1; cfg_taps = CW'(3); cfg_outputs = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("n0_busy", longint'(busy), 1);
    checkOutput("n0_done", longint'(done), 1);
    checkOutput("n0_psum_valid", longint'(psum_valid), 0);
    @(posedge clk); #1;
    checkOutput("n0_busy_after", longint'(busy), 0);
    checkOutput("n0_done_after", longint'(done), 0);

    for (int i = 0; i < 6; i++) run_vector(tbl[i], 1'b1);

    for (int r = 0; r < 8; r++) begin
`ifdef PE_SEQ_BIAS_EN
      bias_val = longint'($urandom_range(0, 2000)) - 1000;
`endif
      rv = '{k:int'($urandom_range(0, 6)), n:int'($urandom_range(1, 4)), ifm0:0, fltv:0,
             stall:2, bp:0, poke:bit'($urandom_range(0, 1)), exp_first:0, exp_last:0};
      run_vector(rv, 1'b0);
    end

    // Reset mid-MAC: job aborted, outputs cleared, no done pulse afterwards.
    build_job(5, 2, 1'b0, 1, 1);
    start = 1'b1; cfg_taps = CW'(5); cfg_outputs = CW'(2);
    @(posedge clk); #1;
    start = 1'b0; ifm_valid = 1'b1; flt_valid = 1'b1; ifm_data = DW'(9); flt_data = DW'(4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_busy", longint'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mrst_busy", longint'(busy), 0);
    checkOutput("mrst_ifm_ready", longint'(ifm_ready), 0);
    checkOutput("mrst_flt_ready", longint'(flt_ready), 0);
    checkOutput("mrst_pe_ifmap", longint'(pe_ifmap), 0);
    checkOutput("mrst_pe_fltr", longint'(pe_fltr), 0);
    checkOutput("mrst_mult_sel", longint'(pe_mult_sel), 0);
    checkOutput("mrst_acc_clr", longint'(pe_acc_clr), 0);
    checkOutput("mrst_psum_valid", longint'(psum_valid), 0);
    checkOutput("mrst_psum_data", longint'(psum_data), 0);
    checkOutput("mrst_done", longint'(done), 0);
    rst = 1'b0; ifm_valid = 1'b0; flt_valid = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checkOutput("no_done_after_reset", longint'(dones), 0);

`ifdef PE_SEQ_BIAS_EN
    bias_val = -4;
`endif
    run_vector(tbl[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
